fifo_mem_stage: RTL and testbench

Storage and status stage of the 8-entry FIFO, sitting directly downstream of the FIFO address controller. It takes the write/read strobes and 3-bit addresses from the controller, holds the data words in an 8-deep array, and returns registered read data with a valid pulse. It also keeps the occupancy count and the full/empty flags that gate further accesses.

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/fifo_ram8.sv | 48 ++++
 rtl/fifo_mem_stage.sv | 94 +++++++++
 tb/tb_fifo_mem_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-entry FIFO (address controller and storage stage).
// Holds the depth, address and count widths, the default data width, and the
// occupancy-update helper used by every block that tracks the fill level.
package fifo_pkg;

  localparam int FIFO_DEPTH  = 8;
  localparam int FIFO_ADDR_W = 3;
  localparam int FIFO_CNT_W  = 4;
  localparam int FIFO_DATA_W = 8;

  localparam logic [FIFO_CNT_W-1:0] FIFO_CNT_FULL = FIFO_CNT_W'(FIFO_DEPTH);

  // Next occupancy: +1 on write only, -1 on read only, unchanged otherwise.
  // Acceptance rules upstream of this call keep the result inside 0..DEPTH.
  function automatic logic [FIFO_CNT_W-1:0] fifo_cnt_next(
    input logic [FIFO_CNT_W-1:0] cnt,
    input logic                  inc,
    input logic                  dec
  );
    logic [FIFO_CNT_W-1:0] nxt;
    nxt = cnt;
    if (inc && !dec) begin
      nxt = cnt + FIFO_CNT_W'(1);
    end else if (dec && !inc) begin
      nxt = cnt - FIFO_CNT_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fifo_ram8.sv
// fifo_ram8: DEPTH x DATA_W storage array with one synchronous write port and
// one registered read port. A read and write to the same address on the same
// edge returns the old word (read-before-write). Array contents are not reset;
// only the read register is.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (read register only)
//   wr_en    in   write strobe (already qualified by acceptance)
//   wr_addr  in   write location
//   wr_data  in   word to store
//   rd_en    in   read strobe (already qualified by acceptance)
//   rd_addr  in   read location
//   rd_data  out  registered read word, holds when rd_en is low
module fifo_ram8
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [FIFO_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  input  logic [FIFO_ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0]      rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Stage p0 -> p1: registered read. Non-blocking semantics give
  // read-before-write on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_mem_stage.sv
// fifo_mem_stage: storage and status stage of the 8-entry FIFO. Qualifies the
// controller's read/write strobes against full/empty, stores data in
// fifo_ram8, returns registered read data with a one-cycle valid pulse, and
// tracks occupancy with registered full/empty flags.
// Optional feature macro: FIFO_MEM_ERR_EN enables sticky overflow/underflow
// flags; without it both are tied low.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/addr/data     write request from the controller
//   rd_en/addr          read request from the controller
//   rd_data, rd_valid   registered read word and its one-cycle valid pulse
//   count, full, empty  occupancy 0..8 and its derived flags
//   overflow, underflow sticky rejection flags (FIFO_MEM_ERR_EN only)
module fifo_mem_stage
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [FIFO_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  input  logic [FIFO_ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic [FIFO_CNT_W-1:0]  count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   underflow
);

  logic                  rd_acc;
  logic                  wr_acc;
  logic [FIFO_CNT_W-1:0] count_nxt;
  logic                  vld_p1;

  // Stage p0: acceptance. A write at full is only taken when a read frees a
  // slot on the same edge; a read at empty is never taken (no bypass).
  assign rd_acc    = rd_en && !empty;
  assign wr_acc    = wr_en && (!full || rd_acc);
  assign count_nxt = fifo_cnt_next(count, wr_acc, rd_acc);

  fifo_ram8 #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Stage p0 -> p1: valid pulse and status. Flags come from count_nxt so they
  // line up with the registered count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      vld_p1 <= rd_acc;
      count  <= count_nxt;
      full   <= (count_nxt == FIFO_CNT_FULL);
      empty  <= (count_nxt == '0);
    end
  end

  assign rd_valid = vld_p1;

`ifdef FIFO_MEM_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_acc) overflow  <= 1'b1;
      if (rd_en && empty)   underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_mem_stage.sv
// Directed bench for fifo_mem_stage: a vector table walks fill, full-with-
// collision, drain, empty-with-both and idle cases; hand sequences cover the
// reset state and an asynchronous reset in the middle of traffic.
module tb_fifo_mem_stage;

`ifdef FIFO_MEM_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad   = 0;

  fifo_mem_stage #(.DATA_W(8), .DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [2:0] ra;
    logic       vld;
    logic [7:0] rdat;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic we, input logic [2:0] wa, input logic [7:0] wd,
    input logic re, input logic [2:0] ra,
    input logic vld, input logic [7:0] rdat, input logic [3:0] cnt,
    input logic fl, input logic em, input logic ovf, input logic unf);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
    v.vld = vld; v.rdat = rdat; v.cnt = cnt; v.full = fl; v.empty = em;
    v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic re, input logic [2:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);

    // Fill 0x11..0x88 into addresses 0..7.
    for (int i = 0; i < 8; i++) begin
      vecs[i] = mk(1, 3'(i), 8'(8'h11 * (i + 1)), 0, 0,
                   0, 8'h00, 4'(i + 1), (i == 7), 0, 0, 0);
    end
    // Write at full with no read: rejected.
    vecs[8]  = mk(1, 0, 8'h55, 0, 0,  0, 8'h00, 8, 1, 0, 1, 0);
    // Full, read+write same address: old word out, count stays 8.
    vecs[9]  = mk(1, 3, 8'hAA, 1, 3,  1, 8'h44, 8, 1, 0, 1, 0);
    // Drain; address 0 still holds 0x11, address 3 now 0xAA.
    vecs[10] = mk(0, 0, 8'h00, 1, 0,  1, 8'h11, 7, 0, 0, 1, 0);
    vecs[11] = mk(0, 0, 8'h00, 1, 3,  1, 8'hAA, 6, 0, 0, 1, 0);
    vecs[12] = mk(0, 0, 8'h00, 1, 1,  1, 8'h22, 5, 0, 0, 1, 0);
    vecs[13] = mk(0, 0, 8'h00, 1, 2,  1, 8'h33, 4, 0, 0, 1, 0);
    vecs[14] = mk(0, 0, 8'h00, 1, 4,  1, 8'h55, 3, 0, 0, 1, 0);
    vecs[15] = mk(0, 0, 8'h00, 1, 5,  1, 8'h66, 2, 0, 0, 1, 0);
    vecs[16] = mk(0, 0, 8'h00, 1, 6,  1, 8'h77, 1, 0, 0, 1, 0);
    vecs[17] = mk(0, 0, 8'h00, 1, 7,  1, 8'h88, 0, 0, 1, 1, 0);
    // Read at empty: rejected, rd_data holds.
    vecs[18] = mk(0, 0, 8'h00, 1, 0,  0, 8'h88, 0, 0, 1, 1, 1);
    // Empty with both: write taken, read rejected.
    vecs[19] = mk(1, 0, 8'h99, 1, 0,  0, 8'h88, 1, 0, 0, 1, 1);
    // Idle: valid drops, data holds.
    vecs[20] = mk(0, 0, 8'h00, 0, 0,  0, 8'h88, 1, 0, 0, 1, 1);
    vecs[21] = mk(0, 0, 8'h00, 1, 0,  1, 8'h99, 0, 0, 1, 1, 1);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rd_data",   32'(rd_data),   32'h00);
    chk("rst.rd_valid",  32'(rd_valid),  32'h0);
    chk("rst.count",     32'(count),     32'h0);
    chk("rst.full",      32'(full),      32'h0);
    chk("rst.empty",     32'(empty),     32'h1);
    chk("rst.overflow",  32'(overflow),  32'h0);
    chk("rst.underflow", 32'(underflow), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.rd_valid", i),  32'(rd_valid),  32'(vecs[i].vld));
      chk($sformatf("v%0d.rd_data", i),   32'(rd_data),   32'(vecs[i].rdat));
      chk($sformatf("v%0d.count", i),     32'(count),     32'(vecs[i].cnt));
      chk($sformatf("v%0d.full", i),      32'(full),      32'(vecs[i].full));
      chk($sformatf("v%0d.empty", i),     32'(empty),     32'(vecs[i].empty));
      chk($sformatf("v%0d.overflow", i),  32'(overflow),  32'(vecs[i].ovf & ERR_EN));
      chk($sformatf("v%0d.underflow", i), 32'(underflow), 32'(vecs[i].unf & ERR_EN));
    end

    // Asynchronous reset in the middle of traffic.
    @(negedge clk);
    drive(1, 1, 8'h12, 0, 0);
    @(negedge clk);
    drive(1, 2, 8'h34, 0, 0);
    @(negedge clk);
    drive(0, 0, 8'h00, 1, 1);
    @(posedge clk);
    #1;
    chk("mid.rd_valid", 32'(rd_valid), 32'h1);
    chk("mid.rd_data",  32'(rd_data),  32'h12);
    chk("mid.count",    32'(count),    32'h1);
    #2;
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 0, 0);
    #1;
    chk("arst.rd_valid",  32'(rd_valid),  32'h0);
    chk("arst.rd_data",   32'(rd_data),   32'h00);
    chk("arst.count",     32'(count),     32'h0);
    chk("arst.full",      32'(full),      32'h0);
    chk("arst.empty",     32'(empty),     32'h1);
    chk("arst.overflow",  32'(overflow),  32'h0);
    chk("arst.underflow", 32'(underflow), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // After reset the FIFO is empty again: a read is rejected.
    @(negedge clk);
    drive(0, 0, 8'h00, 1, 2);
    @(posedge clk);
    #1;
    chk("post.rd_valid",  32'(rd_valid),  32'h0);
    chk("post.count",     32'(count),     32'h0);
    chk("post.underflow", 32'(underflow), 32'(ERR_EN));
    @(negedge clk);
    drive(0, 0, 8'h00, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
